// File: rtl/mat_switch_port.sv
// Buffered switch port for a matrix core: a circular send FIFO toward the switch fabric and
// a single-outstanding receive engine with a hold register. Payload lanes are IEEE-754 bit patterns.
module mat_switch_port #(
   parameter int unsigned SWITCH_WIDTH          = 16,
   parameter int unsigned SWITCH_CORE_SIZE      = 4,
   parameter int unsigned SEND_DEPTH            = 4,
   parameter int unsigned SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE),
   parameter int unsigned COUNT_SIZE            = $clog2(SEND_DEPTH + 1)
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic                                    core_send_valid,
   input  logic [SWITCH_CORE_ADDR_SIZE-1:0]        core_send_core_idx,
   input  logic [SWITCH_WIDTH-1:0][31:0]           core_send_data,
   output logic                                    core_send_ready,
   output logic [COUNT_SIZE-1:0]                   send_pending,
   output logic                                    switch_send_ready,
   output logic [SWITCH_CORE_ADDR_SIZE-1:0]        switch_send_core_idx,
   output logic [SWITCH_WIDTH-1:0][31:0]           switch_send_data,
   input  logic                                    switch_send_ok,
   input  logic                                    core_recv_request,
   input  logic [SWITCH_CORE_ADDR_SIZE-1:0]        core_recv_core_idx,
   output logic                                    core_recv_valid,
   output logic [SWITCH_WIDTH-1:0][31:0]           core_recv_data,
   input  logic                                    core_recv_ack,
   output logic                                    core_recv_busy,
   output logic                                    switch_recv_request,
   output logic [SWITCH_CORE_ADDR_SIZE-1:0]        switch_recv_core_idx,
   input  logic                                    switch_recv_ready,
   input  logic [SWITCH_WIDTH-1:0][31:0]           switch_recv_data,
   output logic                                    port_idle
);

   localparam int unsigned PTR_W = $clog2(SEND_DEPTH);

   // ---------------- send FIFO ----------------
   logic [SWITCH_CORE_ADDR_SIZE-1:0] idx_mem  [SEND_DEPTH];
   logic [SWITCH_WIDTH-1:0][31:0]    data_mem [SEND_DEPTH];
   logic [PTR_W-1:0]                 wr_ptr_q, rd_ptr_q;
   logic [COUNT_SIZE-1:0]            count_q, count_d;
   logic                             push, pop;

   assign core_send_ready      = (count_q != COUNT_SIZE'(SEND_DEPTH));
   assign switch_send_ready    = (count_q != '0);
   assign send_pending         = count_q;
   assign switch_send_core_idx = idx_mem[rd_ptr_q];
   assign switch_send_data     = data_mem[rd_ptr_q];

   // Ready is from registered occupancy, so a full FIFO never accepts even when popping.
   assign push = core_send_valid && core_send_ready;
   assign pop  = switch_send_ok && switch_send_ready;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + COUNT_SIZE'(1);
         2'b01:   count_d = count_q - COUNT_SIZE'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         idx_mem[wr_ptr_q]  <= core_send_core_idx;
         data_mem[wr_ptr_q] <= core_send_data;
      end
   end

   // ---------------- receive engine ----------------
   typedef enum logic [1:0] {StIdle, StReq, StHold} recv_state_e;

   recv_state_e                      state_q, state_d;
   logic [SWITCH_CORE_ADDR_SIZE-1:0] src_idx_q, src_idx_d;
   logic [SWITCH_WIDTH-1:0][31:0]    hold_q, hold_d;

   always_comb begin
      state_d   = state_q;
      src_idx_d = src_idx_q;
      hold_d    = hold_q;
      case (state_q)
         StIdle: begin
            if (core_recv_request) begin
               src_idx_d = core_recv_core_idx;
               state_d   = StReq;
            end
         end
         StReq: begin
            if (switch_recv_ready) begin
               hold_d  = switch_recv_data;
               state_d = StHold;
            end
         end
         StHold: begin
            if (core_recv_ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         src_idx_q <= '0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         src_idx_q <= src_idx_d;
         hold_q    <= hold_d;
      end
   end

   assign switch_recv_request  = (state_q == StReq);
   assign switch_recv_core_idx = src_idx_q;
   assign core_recv_valid      = (state_q == StHold);
   assign core_recv_busy       = (state_q != StIdle);
   assign core_recv_data       = hold_q;
   assign port_idle            = (count_q == '0) && (state_q == StIdle);

endmodule

// File: doc/mat_switch_port.md
# mat_switch_port

Buffered, parametrised switch interface for a matrix core: decouples the core's control from the inter-core switch so sends no longer stall the core until `switch_send_ok`. Sits between the core control unit and the switch fabric, replacing the core's direct switch send/recv wiring. It provides a SEND_DEPTH-entry send FIFO and a single-outstanding receive engine with a hold register. It also exports an idle flag for the core's `done` logic.

## Interface
- SWITCH_WIDTH, 16, shortreal elements per switch transfer
- SWITCH_CORE_SIZE, 4, number of addressable cores
- SEND_DEPTH, 4, send FIFO entries (power of two, ≥2)
- SWITCH_CORE_ADDR_SIZE, $clog2(SWITCH_CORE_SIZE), derived
- COUNT_SIZE, $clog2(SEND_DEPTH+1), derived

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- core_send_valid  in  1  core offers a send entry
- core_send_core_idx  in  SWITCH_CORE_ADDR_SIZE  destination core
- core_send_data  in  SWITCH_WIDTH×shortreal  payload
- core_send_ready  out  1  FIFO not full
- send_pending  out  COUNT_SIZE  FIFO occupancy
- switch_send_ready  out  1  FIFO head valid
- switch_send_core_idx  out  SWITCH_CORE_ADDR_SIZE  head destination
- switch_send_data  out  SWITCH_WIDTH×shortreal  head payload
- switch_send_ok  in  1  switch accepts head
- core_recv_request  in  1  core requests data from a source core
- core_recv_core_idx  in  SWITCH_CORE_ADDR_SIZE  source core
- core_recv_valid  out  1  hold register valid
- core_recv_data  out  SWITCH_WIDTH×shortreal  received payload
- core_recv_ack  in  1  core consumed received payload
- core_recv_busy  out  1  receive engine not IDLE
- switch_recv_request  out  1  registered request to switch
- switch_recv_core_idx  out  SWITCH_CORE_ADDR_SIZE  registered source index
- switch_recv_ready  in  1  switch presents data
- switch_recv_data  in  SWITCH_WIDTH×shortreal  switch payload
- port_idle  out  1  send_pending==0 and receive engine IDLE

## Operation
- Send FIFO: circular buffer, read/write pointers wrap modulo SEND_DEPTH, occupancy counter 0..SEND_DEPTH.
- Push on rising edge when core_send_valid && core_send_ready; pop when switch_send_ok && switch_send_ready.
- core_send_ready = (send_pending != SEND_DEPTH); no bypass when full, even if a pop occurs in the same cycle.
- switch_send_ready = (send_pending != 0). Head idx/data are driven from FIFO storage and stay stable until popped.
- Push and pop in the same cycle: occupancy unchanged, both pointers advance.
- switch_send_ok while FIFO empty: ignored.
- Receive FSM states:
  - IDLE: core_recv_request latches core_recv_core_idx → REQ.
  - REQ: switch_recv_request=1. On switch_recv_ready, capture switch_recv_data into the hold register → HOLD.
  - HOLD: core_recv_valid=1. On core_recv_ack → IDLE.
- core_recv_request outside IDLE: ignored; core must wait for !core_recv_busy.
- core_recv_ack outside HOLD: ignored.
- switch_recv_ready outside REQ: ignored.
- core_recv_data holds its last captured value after returning to IDLE.
- Send and receive paths are fully independent.

## Timing
- Reset low, asynchronously:
  - pointers and occupancy → 0
  - FSM → IDLE
  - switch_send_ready, switch_recv_request, core_recv_valid, core_recv_busy → 0
  - switch_recv_core_idx → 0; hold register → 0.0 all lanes
  - core_send_ready → 1; port_idle → 1
  - FIFO contents discarded
- Reset mid-transfer (REQ or HOLD): request and valid drop immediately; no partial state survives.
- Send latency: push at edge N gives switch_send_ready=1 from edge N (registered occupancy), i.e. visible in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- Receive latency, from core_recv_request sampled at edge N:
  - switch_recv_request high after edge N.
  - switch_recv_ready sampled at edge M gives core_recv_valid high after edge M.
  - core_recv_ack at edge K gives IDLE after K; the earliest next request is sampled at K+1.
- All outputs are registered or derived from registered state only. There are no input-to-output combinational paths.

## Test plan
- Reset, then push 4 entries (idx 1,2,3,0; lane0 = 1.0..4.0) with switch_send_ok=0 → core_send_ready=0 after the 4th, send_pending=4, head idx=1, lane0=1.0.
- Full FIFO with switch_send_ok and core_send_valid both high for one cycle → one pop, no push, send_pending=3, head lane0=2.0.
- Streaming with switch_send_ok held high for 10 back-to-back pushes → order preserved, pointers wrap, send_pending ≤1 throughout.
- core_recv_request idx=2, switch_recv_ready after 3 cycles with lane5=7.5 → switch_recv_core_idx=2, core_recv_valid=1, core_recv_data[5]=7.5. A second request while in HOLD is ignored. After ack → IDLE and port_idle=1.
- Reset pulsed low while in REQ with 2 FIFO entries → switch_recv_request drops without a clock edge, send_pending=0, port_idle=1.
- switch_recv_ready and core_recv_ack asserted in IDLE → no state change, core_recv_valid stays 0.
